karat_mul_arbiter: RTL and testbench
====================================

Name: karat_mul_arbiter

Overview:
Shares one combinational 16x16 Karatsuba multiplier (`karat`: X, Y -> XY) between NREQ requesters. It performs round-robin arbitration, registers the operands, and returns the 32-bit product with the winner's ID over a valid/ready response channel. Upstream blocks issue multiply requests; one downstream consumer drains results.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), width of requester ID.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  per-requester request valid.
req_x  in  16*NREQ  flattened X operands; requester i uses bits [16i+15:16i].
req_y  in  16*NREQ  flattened Y operands; same slicing as req_x.
req_ready  out  NREQ  one-hot grant/accept strobe.
resp_valid  out  1  result valid.
resp_ready  in  1  consumer accepts result.
resp_xy  out  32  product X*Y.
resp_id  out  IDW  index of the requester that owns the result.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE.
  - req_ready = 0, resp_valid = 0, resp_xy = 0, resp_id = 0, busy = 0.
  - Operand registers = 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has priority first.
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is high, pick winner g = first set bit searching upward from last_grant+1, wrapping modulo NREQ.
  - req_ready[g] = 1 combinationally in that cycle. All other req_ready bits = 0.
  - On that edge: capture x_q = req_x slice g, y_q = req_y slice g, id_q = g; set last_grant = g; go to CALC.
  - If no req_valid: stay in IDLE with req_ready = 0.
- CALC:
  - karat instance computes from x_q / y_q.
  - On the edge: resp_xy <= XY, resp_id <= id_q, resp_valid <= 1; go to RESP.
- RESP:
  - resp_valid held high; resp_xy and resp_id held stable.
  - When resp_valid && resp_ready: resp_valid <= 0; go to IDLE.
- req_ready = 0 in CALC and RESP.
- Latency: request accept edge -> resp_valid high 2 edges later. Best-case throughput is 1 result per 3 cycles.
- Requester rules:
  - Requesters must hold req_valid and operands stable until their req_ready pulse.
  - Deasserting req_valid before the grant is allowed; the request is simply not served.
- Arithmetic: resp_xy is the full unsigned 32-bit product; no truncation or overflow is possible.
- Boundary cases:
  - All requesters valid continuously: grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ grants.
  - resp_ready already high when resp_valid rises: handshake completes in the first RESP cycle.
  - Requests arriving while busy: left pending, since req_ready stays 0.
  - rst_n asserted mid-operation (any state): in-flight result discarded, all state returns to reset values immediately, no spurious resp_valid.

Optional Feature:
KARAT_ARB_STATS_EN
- Defined:
  - Adds output `op_count` [15:0], reset to 0.
  - Increments on each completed response handshake and saturates at 16'hFFFF.
  - Adds output `stall_count` [15:0], reset to 0.
  - Increments each cycle that resp_valid && !resp_ready and saturates at 16'hFFFF.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Shared package `karat_pkg` holds:
  - constants OPW = 16 and PRW = 32;
  - typedef enum logic [1:0] {IDLE, CALC, RESP} karat_arb_state_t.
- Sub-module `rr_arbiter` (params NREQ, IDW):
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, encoded grant index, any_req.
- The existing `karat` multiplier is instantiated unchanged.

Test Plan:
- Requester 0 only, X=3, Y=5, resp_ready=1 -> req_ready[0] pulses one cycle; 2 edges later resp_valid=1, resp_xy=15, resp_id=0; busy falls after the handshake.
- Back-to-back products on requester 2, with {X,Y} in turn {255,255}, {1234,5678}, {65535,65535} -> resp_xy 65025, 7006652, 4294836225; resp_id=2 each time; one result per 3 cycles.
- All 4 requesters valid continuously with distinct operands -> grant order 0,1,2,3,0,1; each resp_xy matches its own requester's X*Y.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid, with X=15, Y=7 -> resp_xy=105 held stable, resp_valid held, req_ready all 0; completes the cycle resp_ready rises.
- rst_n pulsed low during CALC, then released -> all outputs 0, no resp_valid; the next request from requester 1 is granted normally.
- With KARAT_ARB_STATS_EN, 3 completed ops plus 4 stall cycles -> op_count=3, stall_count=4.

Source files
------------

// File: rtl/karat_pkg.sv
// Shared definitions for the Karatsuba multiplier arbiter slice.
//   OPW               : operand width of the shared multiplier
//   PRW               : product width
//   karat_arb_state_t : arbiter FSM state encoding
package karat_pkg;

    localparam int unsigned OPW = 16;
    localparam int unsigned PRW = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } karat_arb_state_t;

endpackage : karat_pkg

// File: rtl/karat.sv
// Combinational 16x16 unsigned Karatsuba multiplier.
// Ports:
//   X  [OPW-1:0] : multiplicand
//   Y  [OPW-1:0] : multiplier
//   XY [PRW-1:0] : full unsigned product X*Y
module karat
    import karat_pkg::*;
(
    input  logic [OPW-1:0] X,
    input  logic [OPW-1:0] Y,
    output logic [PRW-1:0] XY
);

    localparam int unsigned H = OPW / 2;

    logic [H-1:0]     xh, xl, yh, yl;
    logic [H:0]       xs, ys;
    logic [2*H-1:0]   z2, z0;
    logic [2*H+1:0]   zm;
    logic [PRW-1:0]   z1;

    assign xh = X[OPW-1:H];
    assign xl = X[H-1:0];
    assign yh = Y[OPW-1:H];
    assign yl = Y[H-1:0];

    assign z2 = {{H{1'b0}}, xh} * {{H{1'b0}}, yh};
    assign z0 = {{H{1'b0}}, xl} * {{H{1'b0}}, yl};

    assign xs = {1'b0, xh} + {1'b0, xl};
    assign ys = {1'b0, yh} + {1'b0, yl};
    assign zm = {{(H+1){1'b0}}, xs} * {{(H+1){1'b0}}, ys};

    // Middle term: (xh+xl)(yh+yl) - xh*yh - xl*yl = xh*yl + xl*yh, never negative.
    assign z1 = PRW'(zm) - PRW'(z2) - PRW'(z0);

    assign XY = (PRW'(z2) << (2*H)) + (z1 << H) + PRW'(z0);

endmodule : karat

// File: rtl/karat_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index searching upward
// from last_grant_i+1, wrapping modulo NREQ.
// Ports:
//   req_i        [NREQ-1:0] : request vector
//   last_grant_i [IDW-1:0]  : index granted most recently
//   grant_o      [NREQ-1:0] : one-hot grant (zero if no request)
//   grant_idx_o  [IDW-1:0]  : encoded grant index
//   any_req_o               : at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_req_o
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IDW'((32'(last_grant_i) + off) % NREQ);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule : rr_arbiter

// File: rtl/karat_mul_arbiter.sv
// Shares one combinational Karatsuba multiplier between NREQ requesters with
// round-robin arbitration and a valid/ready result channel.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req_valid    : per-requester request valid
//   req_x, req_y : flattened operands, requester i uses [16i+15:16i]
//   req_ready    : one-hot accept strobe (IDLE only)
//   resp_valid / resp_ready : result handshake
//   resp_xy      : 32-bit product, resp_id : owning requester
//   busy         : FSM not in IDLE
// Optional (macro KARAT_ARB_STATS_EN):
//   op_count     : completed response handshakes, saturating
//   stall_count  : cycles with resp_valid && !resp_ready, saturating
module karat_mul_arbiter
    import karat_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [OPW*NREQ-1:0]   req_x,
    input  logic [OPW*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [PRW-1:0]        resp_xy,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy
`ifdef KARAT_ARB_STATS_EN
    ,
    output logic [15:0]           op_count,
    output logic [15:0]           stall_count
`endif
);

    karat_arb_state_t state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [OPW-1:0]   x_q, x_d;
    logic [OPW-1:0]   y_q, y_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [PRW-1:0]   resp_xy_q, resp_xy_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic             resp_valid_q, resp_valid_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_req;
    logic [PRW-1:0]   xy;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .any_req_o    (any_req)
    );

    karat u_karat (
        .X  (x_q),
        .Y  (y_q),
        .XY (xy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= '0;
            resp_xy_q    <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            resp_xy_q    <= resp_xy_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        resp_xy_d    = resp_xy_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready    = grant;
                    x_d          = req_x[32'(grant_idx)*OPW +: OPW];
                    y_d          = req_y[32'(grant_idx)*OPW +: OPW];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = CALC;
                end
            end
            CALC: begin
                resp_xy_d    = xy;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_xy    = resp_xy_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != IDLE);

`ifdef KARAT_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (resp_valid_q && resp_ready && (op_count_q != '1)) begin
            op_count_d = op_count_q + 16'd1;
        end
        if (resp_valid_q && !resp_ready && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule : karat_mul_arbiter

// File: tb/tb_karat_mul_arbiter.sv
module tb_karat_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_x;
    logic [16*NREQ-1:0]   req_y;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_xy;
    logic [IDW-1:0]       resp_id;
    logic                 busy;
`ifdef KARAT_ARB_STATS_EN
    logic [15:0]          op_count;
    logic [15:0]          stall_count;
`endif

    karat_mul_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_xy    (resp_xy),
        .resp_id    (resp_id),
        .busy       (busy)
`ifdef KARAT_ARB_STATS_EN
        ,
        .op_count   (op_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_last = NREQ - 1;

    typedef struct {
        int          id;
        logic [31:0] xy;
    } exp_t;
    exp_t sb[$];

    // Reference round-robin choice from the bench's own pointer.
    function automatic int model_pick(logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (exp_last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int i);
        logic [NREQ-1:0] o;
        o = '0;
        if (i >= 0) o[i] = 1'b1;
        return o;
    endfunction

    task automatic set_req(int i, logic [15:0] x, logic [15:0] y);
        req_valid[i]       = 1'b1;
        req_x[16*i +: 16]  = x;
        req_y[16*i +: 16]  = y;
    endtask

    task automatic push_exp(int g);
        exp_t e;
        e.id = g;
        e.xy = 32'(req_x[16*g +: 16]) * 32'(req_y[16*g +: 16]);
        sb.push_back(e);
        exp_last = g;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_last = NREQ - 1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_xy !== 32'd0) begin n_err++; $display("FAIL reset_resp_xy: got %0d want 0", resp_xy); end
        n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef KARAT_ARB_STATS_EN
        n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_last = NREQ - 1;
    endtask

    task automatic test_single();
        bit   ok;
        int   g;
        int   gcyc;
        exp_t e;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        set_req(0, 16'd3, 16'd5);
        g = model_pick(req_valid);
        wait_grant(ok);
        n_cmp++; if (!ok || req_ready !== onehot(g)) begin n_err++; $display("FAIL single_grant: got %b want %b", req_ready, onehot(g)); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        push_exp(g);
        gcyc = cyc;
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_calc: got %b want 1", busy); end
        wait_resp(ok);
        n_cmp++; if (!ok || (cyc - gcyc) != 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", cyc - gcyc); end
        e = sb.pop_front();
        n_cmp++; if (resp_xy !== 32'd15 || resp_xy !== e.xy) begin n_err++; $display("FAIL single_xy: got %0d want %0d", resp_xy, e.xy); end
        n_cmp++; if (resp_id !== IDW'(e.id)) begin n_err++; $display("FAIL single_id: got %0d want %0d", resp_id, e.id); end
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_handshake: got %b want 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] tx [3];
        logic [15:0] ty [3];
        logic [31:0] tp [3];
        bit   ok;
        int   g;
        int   prev;
        exp_t e;
        tx[0] = 16'd255;   ty[0] = 16'd255;   tp[0] = 32'd65025;
        tx[1] = 16'd1234;  ty[1] = 16'd5678;  tp[1] = 32'd7006652;
        tx[2] = 16'd65535; ty[2] = 16'd65535; tp[2] = 32'd4294836225;
        prev = 0;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        set_req(2, tx[0], ty[0]);
        for (int k = 0; k < 3; k++) begin
            g = model_pick(req_valid);
            wait_grant(ok);
            n_cmp++; if (!ok || req_ready !== onehot(g)) begin n_err++; $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, onehot(g)); end
            if (k > 0) begin
                n_cmp++; if ((cyc - prev) != 3) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d want 3", k, cyc - prev); end
            end
            prev = cyc;
            push_exp(g);
            @(posedge clk); #1;
            if (k < 2) set_req(2, tx[k+1], ty[k+1]);
            else req_valid = '0;
            wait_resp(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout%0d: got no resp want resp", k); end
            e = sb.pop_front();
            n_cmp++; if (resp_xy !== tp[k] || e.xy !== tp[k]) begin n_err++; $display("FAIL b2b_xy%0d: got %0d want %0d", k, resp_xy, tp[k]); end
            n_cmp++; if (resp_id !== 2'd2) begin n_err++; $display("FAIL b2b_id%0d: got %0d want 2", k, resp_id); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_all_valid();
        bit   ok;
        int   g;
        exp_t e;
        do_reset();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(100 + i*37), 16'(1000*(i+1) + 7));
        for (int k = 0; k < 6; k++) begin
            g = model_pick(req_valid);
            wait_grant(ok);
            n_cmp++; if (!ok || req_ready !== onehot(k % NREQ) || g != (k % NREQ)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, onehot(k % NREQ)); end
            push_exp(g);
            @(posedge clk); #1;
            if (k == 5) req_valid = '0;
            wait_resp(ok);
            n_cmp++; if (!ok || sb.size() == 0) begin n_err++; $display("FAIL rr_timeout%0d: got no resp want resp", k); end
            else begin
                e = sb.pop_front();
                n_cmp++; if (resp_xy !== e.xy) begin n_err++; $display("FAIL rr_xy%0d: got %0d want %0d", k, resp_xy, e.xy); end
                n_cmp++; if (resp_id !== IDW'(e.id)) begin n_err++; $display("FAIL rr_id%0d: got %0d want %0d", k, resp_id, e.id); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   g;
        exp_t e;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_req(0, 16'd15, 16'd7);
        g = model_pick(req_valid);
        wait_grant(ok);
        n_cmp++; if (!ok || req_ready !== onehot(g)) begin n_err++; $display("FAIL bp_grant: got %b want %b", req_ready, onehot(g)); end
        push_exp(g);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 16'd2, 16'd9);
        wait_resp(ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || resp_xy !== 32'd105 || e.xy !== 32'd105) begin n_err++; $display("FAIL bp_xy: got %0d want 105", resp_xy); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (resp_valid !== 1'b1 || resp_xy !== 32'd105 || resp_id !== 2'd0) begin n_err++; $display("FAIL bp_hold%0d: got v=%b xy=%0d id=%0d want v=1 xy=105 id=0", k, resp_valid, resp_xy, resp_id); end
            n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL bp_pending%0d: got %b want 0000", k, req_ready); end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", resp_valid); end
        g = model_pick(req_valid);
        wait_grant(ok);
        n_cmp++; if (!ok || req_ready !== 4'b0010 || req_ready !== onehot(g)) begin n_err++; $display("FAIL bp_pending_grant: got %b want 0010", req_ready); end
        push_exp(g);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || resp_xy !== e.xy || resp_id !== IDW'(e.id)) begin n_err++; $display("FAIL bp_pending_resp: got xy=%0d id=%0d want xy=%0d id=%0d", resp_xy, resp_id, e.xy, e.id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   g;
        exp_t e;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        set_req(0, 16'd40, 16'd50);
        wait_grant(ok);
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_in_calc: got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_xy !== 32'd0 || resp_id !== 2'd0 || req_ready !== 4'b0) begin
            n_err++; $display("FAIL rstmid_clear: got v=%b busy=%b xy=%0d id=%0d rdy=%b want all 0", resp_valid, busy, resp_xy, resp_id, req_ready);
        end
        sb.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        exp_last = NREQ - 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_spurious%0d: got %b want 0", k, resp_valid); end
        end
        set_req(1, 16'd321, 16'd123);
        g = model_pick(req_valid);
        wait_grant(ok);
        n_cmp++; if (!ok || req_ready !== onehot(g)) begin n_err++; $display("FAIL rstmid_grant: got %b want %b", req_ready, onehot(g)); end
        push_exp(g);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || resp_xy !== 32'd39483 || resp_xy !== e.xy || resp_id !== 2'd1) begin n_err++; $display("FAIL rstmid_resp: got xy=%0d id=%0d want xy=39483 id=1", resp_xy, resp_id); end
        @(posedge clk); #1;
    endtask

`ifdef KARAT_ARB_STATS_EN
    task automatic test_stats();
        bit   ok;
        int   g;
        exp_t e;
        do_reset();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(3, 16'(11 + k), 16'(200 + k));
            g = model_pick(req_valid);
            wait_grant(ok);
            push_exp(g);
            @(posedge clk); #1;
            req_valid = '0;
            if (k == 1) resp_ready = 1'b0;
            wait_resp(ok);
            e = sb.pop_front();
            n_cmp++; if (!ok || resp_xy !== e.xy) begin n_err++; $display("FAIL stats_xy%0d: got %0d want %0d", k, resp_xy, e.xy); end
            if (k == 1) begin
                for (int s = 0; s < 4; s++) begin @(posedge clk); #1; end
                resp_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (k == 0) begin
                n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL stats_op_partial: got %0d want 1", op_count); end
            end
        end
        n_cmp++; if (op_count !== 16'd3) begin n_err++; $display("FAIL stats_op_count: got %0d want 3", op_count); end
        n_cmp++; if (stall_count !== 16'd4) begin n_err++; $display("FAIL stats_stall_count: got %0d want 4", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_all_valid();
        test_backpressure();
        test_reset_mid();
`ifdef KARAT_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule : tb_karat_mul_arbiter
